swc_ll_read_pump_walker: RTL and testbench

Per-port page-chain walker that sits downstream of swc_multiport_linked_list, one instance per output port.
- Given a packet's first page and page count, it follows the next-page pointers by issuing read_pump_read requests on its linked-list channel.
- It presents the resulting page-address sequence to the packet-memory read pump over a valid/ready interface.
- It prefetches one next-pointer ahead, so the linked-list latency is hidden when the consumer is slow.

---
 rtl/swc_ll_pkg.sv | 6 +
 rtl/swc_ll_req_holder.sv | 25 ++
 rtl/swc_ll_read_pump_walker.sv | 102 ++++++++++
 tb/tb_swc_ll_read_pump_walker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swc_ll_pkg.sv
// swc_ll_pkg: shared constants and walker state encoding for the linked-list read path
package swc_ll_pkg;
    localparam int c_page_addr_width = 10;
    localparam int c_num_ports = 11;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
endpackage

// File: rtl/swc_ll_req_holder.sv
// swc_ll_req_holder: level linked-list read request, cleared on done, with latched address
module swc_ll_req_holder import swc_ll_pkg::*; #(
    parameter int g_page_addr_width = c_page_addr_width
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         set,
    input  logic [g_page_addr_width-1:0] set_addr,
    input  logic                         done,
    output logic                         req,
    output logic [g_page_addr_width-1:0] addr
);
    // a new request issued on the done edge keeps req high with the new address
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req <= 1'b0;
            addr <= '0;
        end else if (set) begin
            req <= 1'b1;
            addr <= set_addr;
        end else if (done) begin
            req <= 1'b0;
        end
    end
endmodule

// File: rtl/swc_ll_read_pump_walker.sv
// swc_ll_read_pump_walker: walks a packet's page chain, prefetching one next pointer ahead
module swc_ll_read_pump_walker import swc_ll_pkg::*; #(
    parameter int g_page_addr_width = c_page_addr_width,
    parameter int g_cnt_width = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         pck_start_i,
    input  logic [g_page_addr_width-1:0] pck_first_page_i,
    input  logic [g_cnt_width-1:0]       pck_npages_i,
    output logic                         pck_ready_o,
    output logic                         pck_done_o,
    input  logic                         abort_i,
    output logic                         page_valid_o,
    output logic [g_page_addr_width-1:0] page_addr_o,
    output logic                         page_last_o,
    input  logic                         page_ready_i,
    output logic                         ll_read_req_o,
    output logic [g_page_addr_width-1:0] ll_read_addr_o,
    input  logic                         ll_read_done_i,
    input  logic [g_page_addr_width-1:0] ll_data_i
);
    state_t state;
    logic [g_cnt_width-1:0] remaining;
    logic [g_page_addr_width-1:0] nxt_reg, fwd, set_addr;
    logic nxt_valid, hs, start, adv, set, busy;

    // adv: move to the next page, either on a handshake or once a stalled pointer returns
    always_comb begin
        hs = page_valid_o & page_ready_i;
        start = state == S_IDLE && pck_start_i && pck_npages_i != '0;
        adv = state == S_RUN && !abort_i && (nxt_valid || ll_read_done_i) && (page_valid_o ? hs && !page_last_o : 1'b1);
        fwd = nxt_valid ? nxt_reg : ll_data_i;
        set = start ? pck_npages_i > g_cnt_width'(1) : adv && remaining > g_cnt_width'(1);
        set_addr = start ? pck_first_page_i : fwd;
        busy = ll_read_req_o && !ll_read_done_i;
    end

    swc_ll_req_holder #(.g_page_addr_width(g_page_addr_width)) u_req (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .set(set),
        .set_addr(set_addr),
        .done(ll_read_done_i),
        .req(ll_read_req_o),
        .addr(ll_read_addr_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            pck_ready_o <= 1'b1;
            pck_done_o <= 1'b0;
            page_valid_o <= 1'b0;
            page_addr_o <= '0;
            page_last_o <= 1'b0;
            remaining <= '0;
            nxt_reg <= '0;
            nxt_valid <= 1'b0;
        end else begin
            pck_done_o <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    page_valid_o <= 1'b1;
                    page_addr_o <= pck_first_page_i;
                    page_last_o <= pck_npages_i == g_cnt_width'(1);
                    remaining <= pck_npages_i - 1'b1;
                    pck_ready_o <= 1'b0;
                    nxt_valid <= 1'b0;
                    state <= S_RUN;
                end
                S_RUN: if (abort_i) begin
                    page_valid_o <= 1'b0;
                    nxt_valid <= 1'b0;
                    state <= busy ? S_DRAIN : S_IDLE;
                    pck_ready_o <= !busy;
                end else if (adv) begin
                    page_valid_o <= 1'b1;
                    page_addr_o <= fwd;
                    page_last_o <= remaining == g_cnt_width'(1);
                    remaining <= remaining - 1'b1;
                    nxt_valid <= 1'b0;
                end else if (hs) begin
                    page_valid_o <= 1'b0;
                    pck_done_o <= page_last_o;
                    if (page_last_o) begin
                        state <= S_IDLE;
                        pck_ready_o <= 1'b1;
                    end
                end else if (ll_read_done_i) begin
                    nxt_reg <= ll_data_i;
                    nxt_valid <= 1'b1;
                end
                S_DRAIN: if (ll_read_done_i) begin
                    state <= S_IDLE;
                    pck_ready_o <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_swc_ll_read_pump_walker.sv
// tb_swc_ll_read_pump_walker: linked-list model next(p)=p+1, packet-level page scoreboard, directed cases
module tb_swc_ll_read_pump_walker;
    localparam int AW = 10;
    localparam int CW = 7;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, pready = 0, ldone = 0;
    logic [AW-1:0] first = 0, ldata = 0;
    logic [CW-1:0] npages = 0;
    logic ready, pdone, pvalid, plast, lreq;
    logic [AW-1:0] paddr, laddr;

    int checks = 0, failures = 0;
    int lat = 3, cnt = 0, req_cycles = 0, e, n, n0, k;
    logic [AW-1:0] lat_addr = 0;
    int req_log[$];
    int exp_q[$];
    bit exp_done = 0, pv_q = 0, pr_q = 0;
    logic [AW-1:0] pa_q = 0;
    logic pl_q = 0;
    logic [15:0] pat = 16'hB2E6;

    always #5 clk = ~clk;

    swc_ll_read_pump_walker dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .pck_start_i(start),
        .pck_first_page_i(first),
        .pck_npages_i(npages),
        .pck_ready_o(ready),
        .pck_done_o(pdone),
        .abort_i(abort),
        .page_valid_o(pvalid),
        .page_addr_o(paddr),
        .page_last_o(plast),
        .page_ready_i(pready),
        .ll_read_req_o(lreq),
        .ll_read_addr_o(laddr),
        .ll_read_done_i(ldone),
        .ll_data_i(ldata)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // linked list: answers each request after lat cycles with addr+1
    always @(negedge clk) begin
        ldone = 0;
        if (!rst_n) cnt = 0;
        else if (cnt != 0) begin
            chk("ll_hold", {lreq, laddr}, {1'b1, lat_addr});
            cnt--;
            if (cnt == 0) begin
                ldone = 1;
                ldata = lat_addr + 1'b1;
            end
        end else if (lreq) begin
            req_log.push_back(int'(laddr));
            lat_addr = laddr;
            cnt = lat;
        end
        if (lreq) req_cycles++;
    end

    // scoreboard: each accepted packet must yield pages first..first+n-1, last flag on the final one
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 0;
            pv_q = 0;
        end else begin
            chk("done_pulse", pdone, exp_done);
            exp_done = 0;
            if (pv_q && !pr_q && pvalid) begin
                chk("hold_addr", paddr, pa_q);
                chk("hold_last", plast, pl_q);
            end
            if (abort && !ready) exp_q.delete();
            else if (pvalid && pready) begin
                if (exp_q.size() == 0) chk("page_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("page_addr", paddr, e);
                    chk("page_last", plast, exp_q.size() == 0);
                    exp_done = exp_q.size() == 0;
                end
            end
            if (start && ready && npages != 0)
                for (int i = 0; i < int'(npages); i++) exp_q.push_back((int'(first) + i) % 1024);
            pv_q = pvalid && !(abort && !ready);
            pr_q = pready;
            pa_q = paddr;
            pl_q = plast;
        end
    end

    task automatic start_pkt(input int f, input int np);
        @(negedge clk);
        first = AW'(f);
        npages = CW'(np);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!pdone && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", pdone, 1);
    endtask

    task automatic wait_ll_done(input string name);
        int m;
        m = 0;
        while (!ldone && m < 50) begin
            @(negedge clk);
            #1;
            m++;
        end
        chk(name, ldone, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valid", pvalid, 0);
        chk("rst_req", lreq, 0);
        chk("rst_done", pdone, 0);
        rst_n = 1;

        pready = 1;
        n0 = req_log.size();
        start_pkt(5, 4);
        chk("t1_first_valid", pvalid, 1);
        chk("t1_first_addr", paddr, 5);
        wait_done(n);
        chk("t1_latency", n, 14);
        chk("t1_nreq", req_log.size() - n0, 3);
        chk("t1_req0", req_log[n0], 5);
        chk("t1_req1", req_log[n0 + 1], 6);
        chk("t1_req2", req_log[n0 + 2], 7);

        n0 = req_cycles;
        start_pkt(100, 1);
        chk("t2_addr", paddr, 100);
        chk("t2_last", plast, 1);
        wait_done(n);
        chk("t2_latency", n, 2);
        chk("t2_noreq", req_cycles - n0, 0);

        pready = 0;
        n0 = req_log.size();
        start_pkt(5, 3);
        repeat (10) @(negedge clk);
        chk("t3_hold_addr", paddr, 5);
        chk("t3_one_req", req_log.size() - n0, 1);
        chk("t3_req_idle", lreq, 0);
        pready = 1;
        @(negedge clk);
        chk("t3_prefetch_valid", pvalid, 1);
        chk("t3_prefetch_addr", paddr, 6);
        wait_done(n);

        pready = 0;
        start_pkt(30, 3);
        wait_ll_done("t4_coincide");
        pready = 1;
        @(negedge clk);
        chk("t4_fwd_valid", pvalid, 1);
        chk("t4_fwd_addr", paddr, 31);
        chk("t4_fwd_last", plast, 0);
        wait_done(n);

        pready = 0;
        start_pkt(20, 4);
        @(negedge clk);
        chk("t5_req_before", lreq, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("t5_valid_drop", pvalid, 0);
        chk("t5_req_held", lreq, 1);
        chk("t5_not_ready", ready, 0);
        wait_ll_done("t5_ll_done");
        @(negedge clk);
        chk("t5_ready", ready, 1);
        chk("t5_req_drop", lreq, 0);
        chk("t5_no_done", pdone, 0);

        pready = 1;
        start_pkt(40, 5);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("t6_valid", pvalid, 0);
        chk("t6_addr", paddr, 0);
        chk("t6_last", plast, 0);
        chk("t6_done", pdone, 0);
        chk("t6_req", lreq, 0);
        chk("t6_raddr", laddr, 0);
        chk("t6_ready", ready, 1);
        rst_n = 1;
        n0 = req_cycles;
        start_pkt(50, 0);
        chk("t6_zero_ready", ready, 1);
        chk("t6_zero_valid", pvalid, 0);
        repeat (3) @(negedge clk);
        chk("t6_zero_noreq", req_cycles - n0, 0);

        lat = 1;
        start_pkt(200, 6);
        k = 0;
        while (!pdone && k < 200) begin
            @(negedge clk);
            pready = pat[k % 16];
            start = k == 3;
            first = 7;
            npages = 2;
            k++;
        end
        start = 0;
        chk("t7_done", pdone, 1);
        repeat (3) @(negedge clk);
        chk("t7_idle", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
